// File: rtl/iomem_i2s_tx.sv
// iomem_i2s_tx: PicoSoC iomem slave feeding an I2S transmitter.
//   Firmware pushes packed stereo samples (L[31:16], R[15:0]) into a FIFO.
//   The serializer drains it as I2S bus master (bclk, lrclk, sdout).
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   iomem_valid/ready     bus handshake, ready pulses one cycle after a hit
//   iomem_wstrb/addr/wdata  request (wstrb==0 means read)
//   iomem_rdata           read data, valid while iomem_ready=1
//   i2s_bclk/lrclk/sdout  I2S outputs (lrclk 0 = left, MSB first)
//   fifo_level            current FIFO entry count
// Register map (addr[3:2]): 0 DATA(wo push), 1 STATUS(ro), 2 CTRL, 3 reserved.
module iomem_i2s_tx #(
  parameter logic [7:0] ADDR_HI    = 8'h04,
  parameter int         FIFO_DEPTH = 16,
  parameter int         BCLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdout,
  output logic [8:0]  fifo_level
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              DW        = $clog2(BCLK_DIV);
  localparam logic [8:0]      DEPTH_LVL = 9'(FIFO_DEPTH);
  localparam logic [DW-1:0]   DIV_LAST  = DW'(BCLK_DIV - 1);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [8:0]    level_q, level_d;
  logic          en_q, en_d, und_q, und_d, ovf_q, ovf_d;
  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [4:0]    p_q, p_d;
  logic [31:0]   sh_q, sh_d;

  logic       hit, wr, rd, full, empty, tick, fall, load, pop, push_req, push;
  logic       und_set, ovf_set, ctrl_wr;
  logic [1:0] sel;
  logic       unused_addr;

  assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

  assign hit   = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
  assign wr    = hit && (iomem_wstrb != 4'd0);
  assign rd    = hit && (iomem_wstrb == 4'd0);
  assign sel   = iomem_addr[3:2];
  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == 9'd0);

  // Serializer timing: tick = divider terminal count, fall = bclk 1->0.
  // The frame load happens on the fall that moves p from 0 to 1.
  assign tick     = en_q && (div_q == DIV_LAST);
  assign fall     = tick && bclk_q;
  assign load     = fall && (p_q == 5'd0);
  assign pop      = load && !empty;
  assign und_set  = load && empty;
  assign push_req = wr && (sel == 2'd0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ctrl_wr  = wr && (sel == 2'd2);

  always_comb begin
    ready_d = hit;
    rdata_d = '0;
    if (rd) begin
      case (sel)
        2'd1:    rdata_d = {19'd0, ovf_q, und_q, empty, full, level_q};
        2'd2:    rdata_d = {31'd0, en_q};
        default: rdata_d = '0;
      endcase
    end

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 9'd1;
      2'b01:   level_d = level_q - 9'd1;
      default: level_d = level_q;
    endcase

    en_d  = ctrl_wr ? iomem_wdata[0] : en_q;
    // Clear first, set last: a simultaneous set wins.
    und_d = und_q;
    if (ctrl_wr && iomem_wdata[1]) und_d = 1'b0;
    if (und_set)                   und_d = 1'b1;
    ovf_d = ovf_q;
    if (ctrl_wr && iomem_wdata[2]) ovf_d = 1'b0;
    if (ovf_set)                   ovf_d = 1'b1;

    div_d  = div_q;
    bclk_d = bclk_q;
    p_d    = p_q;
    sh_d   = sh_q;
    if (!en_q) begin
      div_d  = '0;
      bclk_d = 1'b0;
      p_d    = '0;
      sh_d   = '0;
    end else if (tick) begin
      div_d  = '0;
      bclk_d = !bclk_q;
      if (bclk_q) begin
        p_d = p_q + 5'd1;
        if (load) sh_d = empty ? 32'd0 : mem_q[rptr_q];
        else      sh_d = {sh_q[30:0], 1'b0};
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Storage needs no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= iomem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      en_q    <= 1'b0;
      und_q   <= 1'b0;
      ovf_q   <= 1'b0;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      p_q     <= '0;
      sh_q    <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      en_q    <= en_d;
      und_q   <= und_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      p_q     <= p_d;
      sh_q    <= sh_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = p_q[4];
  assign i2s_sdout   = sh_q[31];
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_iomem_i2s_tx.sv
// Bench for iomem_i2s_tx: register-access vector table, directed I2S
// corner sequences, and randomized frames checked by an I2S receiver model.
module tb_iomem_i2s_tx;

  localparam logic [31:0] A_DATA = 32'h0400_0000;
  localparam logic [31:0] A_STAT = 32'h0400_0004;
  localparam logic [31:0] A_CTRL = 32'h0400_0008;
  localparam logic [31:0] A_RSV  = 32'h0400_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        i2s_bclk, i2s_lrclk, i2s_sdout;
  logic [8:0]  fifo_level;

  iomem_i2s_tx #(.ADDR_HI(8'h04), .FIFO_DEPTH(16), .BCLK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdout(i2s_sdout),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc_n = 0, ready_cyc = 0;

  // I2S receiver model: samples sdout on bclk rising edges; rise k sits in
  // slot k%32, a word is bits from slots 1..31 plus slot 0 of the next frame.
  bit          rx_on = 0, rose_now = 0, seen_fall = 0;
  int          rise_cnt = 0, last_rise = 0, last_lr = -1, first_rise_cyc = 0;
  int          per_bad = 0, lr_bad = 0;
  logic [8:0]  first_fall_level = '0;
  logic        bclk_prev = 1'b0, lr_prev = 1'b0;
  logic [31:0] rx_sh = '0;
  logic [31:0] rx_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    int slot;
    @(negedge clk);
    cyc_n++;
    rose_now = 0;
    if (rx_on) begin
      if (!bclk_prev && i2s_bclk) begin
        rose_now = 1;
        slot = rise_cnt % 32;
        if (i2s_lrclk !== (slot >= 16)) lr_bad++;
        if (rise_cnt == 0) first_rise_cyc = cyc_n;
        else if (cyc_n - last_rise != 8) per_bad++;
        last_rise = cyc_n;
        if (rise_cnt > 0) begin
          rx_sh = {rx_sh[30:0], i2s_sdout};
          if (slot == 0) rx_q.push_back(rx_sh);
        end
        rise_cnt++;
      end
      if (bclk_prev && !i2s_bclk && !seen_fall) begin
        seen_fall = 1;
        first_fall_level = fifo_level;
      end
      if (!lr_prev && i2s_lrclk) begin
        if (last_lr >= 0 && cyc_n - last_lr != 256) per_bad++;
        last_lr = cyc_n;
      end
    end
    bclk_prev = i2s_bclk;
    lr_prev   = i2s_lrclk;
  endtask

  task automatic rx_start();
    rx_on = 1; rise_cnt = 0; last_lr = -1; seen_fall = 0; rx_sh = '0;
    rx_q.delete();
  endtask

  function automatic logic [31:0] rxw(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Drives one request right after a negedge; ready must show at the next one.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input bit er, input bit ck, input logic [31:0] ex, input string nm);
    iomem_valid = 1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    cyc();
    check({nm, " ready"}, {31'd0, iomem_ready}, {31'd0, er});
    if (er) ready_cyc = cyc_n;
    if (er && ck) check({nm, " rdata"}, iomem_rdata, ex);
    iomem_valid = 0; iomem_wstrb = 0;
    cyc();
    check({nm, " ready low"}, {31'd0, iomem_ready}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    bus(a, 4'hF, d, 1, 0, 32'd0, nm);
  endtask

  task automatic rdc(input logic [31:0] a, input logic [31:0] ex, input string nm);
    bus(a, 4'h0, 32'd0, 1, 1, ex, nm);
  endtask

  task automatic wait_words(input int n, input string nm);
    int k = 0;
    while (rx_q.size() < n && k < n * 256 + 600) begin cyc(); k++; end
    check({nm, " words received"}, {31'd0, rx_q.size() >= n}, 32'd1);
  endtask

  task automatic wait_slot(input int s, input string nm);
    int k = 0;
    do begin cyc(); k++; end while (!(rose_now && rise_cnt % 32 == s) && k < 600);
    check({nm, " slot wait"}, {31'd0, rose_now && (rise_cnt % 32 == s)}, 32'd1);
  endtask

  task automatic outs_zero(input string nm);
    check({nm, " i2s outs"}, {29'd0, i2s_bclk, i2s_lrclk, i2s_sdout}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          rdy;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] words[17];
  logic [31:0] exq[$];

  initial begin
    reset = 1; iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
    repeat (3) cyc();
    check("rst ready", {31'd0, iomem_ready}, 32'd0);
    check("rst rdata", iomem_rdata, 32'd0);
    check("rst level", {23'd0, fifo_level}, 32'd0);
    outs_zero("rst");
    reset = 0;
    cyc();

    // Register access vectors from reset.
    tbl[0]  = '{A_STAT, 4'h0, 32'h0,          1, 1, 32'h0000_0400};
    tbl[1]  = '{A_DATA, 4'h0, 32'h0,          1, 1, 32'h0};
    tbl[2]  = '{A_DATA, 4'h1, 32'h1234_5678,  1, 0, 32'h0};
    tbl[3]  = '{A_DATA, 4'hF, 32'hAAAA_5555,  1, 0, 32'h0};
    tbl[4]  = '{A_DATA, 4'h8, 32'h0001_FFFF,  1, 0, 32'h0};
    tbl[5]  = '{A_STAT, 4'h0, 32'h0,          1, 1, 32'h0000_0003};
    tbl[6]  = '{A_RSV,  4'hF, 32'hFFFF_FFFF,  1, 0, 32'h0};
    tbl[7]  = '{A_RSV,  4'h0, 32'h0,          1, 1, 32'h0};
    tbl[8]  = '{32'h0300_0000, 4'hF, 32'hDEAD_0000, 0, 0, 32'h0};
    tbl[9]  = '{32'h0300_0004, 4'h0, 32'h0,   0, 0, 32'h0};
    tbl[10] = '{A_CTRL, 4'h0, 32'h0,          1, 1, 32'h0};
    tbl[11] = '{A_STAT, 4'h0, 32'h0,          1, 1, 32'h0000_0003};
    for (int i = 0; i < 12; i++)
      bus(tbl[i].addr, tbl[i].strb, tbl[i].wdata, tbl[i].rdy, tbl[i].chk, tbl[i].exp,
          $sformatf("vec%0d", i));
    repeat (4) cyc();
    outs_zero("disabled");

    // Enable and receive the three queued samples plus one underrun frame.
    rx_start();
    wr(A_CTRL, 32'h1, "ctrl en");
    wait_words(4, "frame1");
    check("first bclk rise delay", first_rise_cyc - ready_cyc, 32'd4);
    check("level after first load", {23'd0, first_fall_level}, 32'd2);
    check("word0", rxw(0), 32'h1234_5678);
    check("word1", rxw(1), 32'hAAAA_5555);
    check("word2", rxw(2), 32'h0001_FFFF);
    check("word3 underrun zero", rxw(3), 32'h0);
    rdc(A_STAT, 32'h0000_0C00, "stat underrun");
    wait_slot(8, "midframe");
    wr(A_CTRL, 32'h3, "clr und");
    rdc(A_STAT, 32'h0000_0400, "stat und cleared");
    rdc(A_CTRL, 32'h1, "ctrl retained");

    // Clear issued in the very cycle the empty-frame load sets underrun.
    wait_slot(1, "setwins");
    repeat (3) cyc();
    wr(A_CTRL, 32'h3, "clr collide");
    rdc(A_STAT, 32'h0000_0C00, "set wins");
    rx_on = 0;
    wr(A_CTRL, 32'h6, "disable");
    repeat (3) cyc();
    outs_zero("after disable");
    rdc(A_STAT, 32'h0000_0400, "stat after disable");

    // Overflow: 17 pushes into a 16-deep FIFO, the last is dropped.
    for (int i = 0; i < 17; i++) begin
      words[i] = $urandom;
      wr(A_DATA, words[i], $sformatf("ovf push%0d", i));
    end
    check("full level", {23'd0, fifo_level}, 32'd16);
    rdc(A_STAT, 32'h0000_1210, "stat full ovf");
    rx_start();
    wr(A_CTRL, 32'h5, "en clr ovf");
    // Push into a full FIFO on the cycle of the pop: accepted, no overflow.
    wait_slot(1, "pushpop");
    repeat (3) cyc();
    wr(A_DATA, 32'hDEAD_BEEF, "push at pop");
    rdc(A_STAT, 32'h0000_0210, "stat pushpop");
    wait_words(18, "ovf drain");
    for (int i = 0; i < 16; i++) check($sformatf("ovf word%0d", i), rxw(i), words[i]);
    check("pushpop word", rxw(16), 32'hDEAD_BEEF);
    check("ovf tail zero", rxw(17), 32'h0);
    rx_on = 0;
    wr(A_CTRL, 32'h6, "disable2");
    repeat (3) cyc();

    // Randomized bursts against the queue model.
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(1, 6);
      exq.delete();
      for (int j = 0; j < n; j++) begin
        exq.push_back($urandom);
        wr(A_DATA, exq[j], "rnd push");
      end
      rdc(A_STAT, 32'(n), $sformatf("rnd%0d stat", it));
      exq.push_back(32'h0);
      rx_start();
      wr(A_CTRL, 32'h1, "rnd en");
      wait_words(n + 1, $sformatf("rnd%0d", it));
      for (int j = 0; j <= n; j++) check($sformatf("rnd%0d word%0d", it, j), rxw(j), exq[j]);
      rdc(A_STAT, 32'h0000_0C00, $sformatf("rnd%0d stat end", it));
      rx_on = 0;
      wr(A_CTRL, 32'h6, "rnd dis");
      repeat (3) cyc();
    end
    check("bclk/lrclk period", 32'(per_bad), 32'd0);
    check("lrclk slot", 32'(lr_bad), 32'd0);

    // Reset mid-frame with level 5.
    for (int j = 0; j < 6; j++) wr(A_DATA, 32'h5A5A_0000 + 32'(j), "rst push");
    wr(A_CTRL, 32'h1, "rst en");
    repeat (40) cyc();
    check("pre-reset level", {23'd0, fifo_level}, 32'd5);
    reset = 1;
    cyc();
    reset = 0;
    check("mid rst level", {23'd0, fifo_level}, 32'd0);
    check("mid rst ready", {31'd0, iomem_ready}, 32'd0);
    check("mid rst rdata", iomem_rdata, 32'd0);
    outs_zero("mid rst");
    rdc(A_CTRL, 32'h0, "ctrl after rst");
    rdc(A_STAT, 32'h0000_0400, "stat after rst");
    bus(32'h0300_0008, 4'h0, 32'h0, 0, 0, 32'h0, "miss addr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
